// File: rtl/kd_tree_pkg.sv
// Shared kd-tree link definitions: bus widths, command codes, axis encoding and leaf states.
// Used by the leaf node, its axis comparator and the bench.
package kd_tree_pkg;

   localparam int COMMAND_SIZE = 5;
   localparam int DATA_SIZE    = 24;
   localparam int CHANNEL_W    = 8;
   localparam int NUM_AXES     = 3;

   localparam logic [COMMAND_SIZE-1:0] CMD_NOP                      = 5'h00;
   localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL              = 5'h01;
   localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL_DONE         = 5'h02;
   localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS      = 5'h03;
   localparam logic [COMMAND_SIZE-1:0] CMD_CONFIGURE_SORT_AXIS_DONE = 5'h04;
   localparam logic [COMMAND_SIZE-1:0] CMD_START_SORTING            = 5'h05;
   localparam logic [COMMAND_SIZE-1:0] CMD_READY_TO_SORT            = 5'h07;
   localparam logic [COMMAND_SIZE-1:0] CMD_SWITCH                   = 5'h08;
   localparam logic [COMMAND_SIZE-1:0] CMD_SORT_LEFT_VALIDATE       = 5'h09;
   localparam logic [COMMAND_SIZE-1:0] CMD_SORT_RIGHT_VALIDATE      = 5'h0A;
   localparam logic [COMMAND_SIZE-1:0] CMD_VALID_SORT               = 5'h0B;
   localparam logic [COMMAND_SIZE-1:0] CMD_BUSY                     = 5'h0C;
   localparam logic [COMMAND_SIZE-1:0] CMD_EXPOSE_CENTER            = 5'h0D;
   localparam logic [COMMAND_SIZE-1:0] CMD_VALID_DONE               = 5'h0E;
   localparam logic [COMMAND_SIZE-1:0] CMD_RST                      = 5'h1D;
   localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE                 = 5'h1E;
   localparam logic [COMMAND_SIZE-1:0] CMD_DNE                      = 5'h1F;

   localparam logic [1:0] AXIS_0       = 2'd0;
   localparam logic [1:0] AXIS_1       = 2'd1;
   localparam logic [1:0] AXIS_2       = 2'd2;
   localparam logic [1:0] AXIS_INVALID = 2'd3;

   typedef enum logic {ST_EMPTY, ST_LOADED} leaf_state_t;

   // The unused fourth axis code folds onto axis 0.
   function automatic logic [1:0] axis_sanitize(input logic [1:0] code);
      return (code == AXIS_INVALID) ? AXIS_0 : code;
   endfunction

endpackage

// File: rtl/kd_axis_cmp.sv
// Combinational compare of one colour channel of two packed RGB words.
// Axis 0 is the most significant channel; le/ge are unsigned a-vs-b results.
module kd_axis_cmp
   import kd_tree_pkg::*;
(
   input  logic [DATA_SIZE-1:0] a_word,
   input  logic [DATA_SIZE-1:0] b_word,
   input  logic [1:0]           axis,
   output logic                 le,
   output logic                 ge
);

   logic [CHANNEL_W-1:0] a_chan [NUM_AXES];
   logic [CHANNEL_W-1:0] b_chan [NUM_AXES];
   logic [CHANNEL_W-1:0] a_sel;
   logic [CHANNEL_W-1:0] b_sel;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_AXES; gi++) begin : g_chan
         assign a_chan[gi] = a_word[DATA_SIZE-1-gi*CHANNEL_W -: CHANNEL_W];
         assign b_chan[gi] = b_word[DATA_SIZE-1-gi*CHANNEL_W -: CHANNEL_W];
      end
   endgenerate

   always_comb begin
      a_sel = a_chan[0];
      b_sel = b_chan[0];
      case (axis)
         AXIS_1: begin a_sel = a_chan[1]; b_sel = b_chan[1]; end
         AXIS_2: begin a_sel = a_chan[2]; b_sel = b_chan[2]; end
         default: ;
      endcase
   end

   assign le = (a_sel <= b_sel);
   assign ge = (a_sel >= b_sel);

endmodule

// File: rtl/kd_leaf_node.sv
// Terminal responder of the kd-tree command link holding at most one RGB center.
// Defining KD_LEAF_STATS_EN adds the saturating switch_count swap counter port.
module kd_leaf_node
   import kd_tree_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [COMMAND_SIZE-1:0] command_from_top,
   input  logic [DATA_SIZE-1:0]    data_from_top,
   output logic [COMMAND_SIZE-1:0] command_to_top,
   output logic [DATA_SIZE-1:0]    data_to_top
`ifdef KD_LEAF_STATS_EN
   ,
   output logic [15:0]             switch_count
`endif
);

   leaf_state_t             state_reg, state_next;
   logic [DATA_SIZE-1:0]    center_reg, center_next;
   logic [1:0]              axis_reg, axis_next;
   logic [COMMAND_SIZE-1:0] prev_cmd_reg;
   logic [COMMAND_SIZE-1:0] cmd_out_reg, cmd_out_next;
   logic [DATA_SIZE-1:0]    data_out_reg, data_out_next;
   logic                    cmp_le, cmp_ge;
   logic                    swap_accept;

   kd_axis_cmp u_axis_cmp (
      .a_word (center_reg),
      .b_word (data_from_top),
      .axis   (axis_reg),
      .le     (cmp_le),
      .ge     (cmp_ge)
   );

   // A held switch level swaps only on the cycle it first appears.
   assign swap_accept = (state_reg == ST_LOADED) && (command_from_top == CMD_SWITCH)
                        && (prev_cmd_reg != CMD_SWITCH);

   always_comb begin
      state_next    = state_reg;
      center_next   = center_reg;
      axis_next     = axis_reg;
      cmd_out_next  = CMD_NOP;
      data_out_next = data_out_reg;
      case (command_from_top)
         CMD_RST: begin
            center_next  = '0;
            axis_next    = AXIS_0;
            state_next   = ST_EMPTY;
            cmd_out_next = CMD_RST_DONE;
         end
         CMD_CENTER_FILL: begin
            if (state_reg == ST_EMPTY) begin
               center_next = data_from_top;
               state_next  = ST_LOADED;
            end
            cmd_out_next = CMD_CENTER_FILL_DONE;
         end
         CMD_CONFIGURE_SORT_AXIS, CMD_START_SORTING, CMD_SWITCH,
         CMD_SORT_LEFT_VALIDATE, CMD_SORT_RIGHT_VALIDATE, CMD_EXPOSE_CENTER: begin
            if (state_reg == ST_EMPTY) begin
               cmd_out_next  = CMD_DNE;
               data_out_next = '0;
            end else begin
               case (command_from_top)
                  CMD_CONFIGURE_SORT_AXIS: begin
                     axis_next    = axis_sanitize(data_from_top[1:0]);
                     cmd_out_next = CMD_CONFIGURE_SORT_AXIS_DONE;
                  end
                  CMD_START_SORTING: begin
                     cmd_out_next  = CMD_READY_TO_SORT;
                     data_out_next = center_reg;
                  end
                  CMD_SWITCH: begin
                     cmd_out_next = CMD_SWITCH;
                     if (swap_accept) begin
                        data_out_next = center_reg;
                        center_next   = data_from_top;
                     end
                  end
                  CMD_SORT_LEFT_VALIDATE:
                     cmd_out_next = cmp_le ? CMD_VALID_SORT : CMD_BUSY;
                  CMD_SORT_RIGHT_VALIDATE:
                     cmd_out_next = cmp_ge ? CMD_VALID_SORT : CMD_BUSY;
                  CMD_EXPOSE_CENTER: begin
                     cmd_out_next  = CMD_VALID_DONE;
                     data_out_next = center_reg;
                  end
                  default: ;
               endcase
            end
         end
         default: cmd_out_next = CMD_NOP;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_EMPTY;
         center_reg   <= '0;
         axis_reg     <= AXIS_0;
         prev_cmd_reg <= CMD_NOP;
         cmd_out_reg  <= CMD_NOP;
         data_out_reg <= '0;
      end else begin
         state_reg    <= state_next;
         center_reg   <= center_next;
         axis_reg     <= axis_next;
         prev_cmd_reg <= command_from_top;
         cmd_out_reg  <= cmd_out_next;
         data_out_reg <= data_out_next;
      end
   end

   assign command_to_top = cmd_out_reg;
   assign data_to_top    = data_out_reg;

`ifdef KD_LEAF_STATS_EN
   logic [15:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count_reg <= '0;
      else if (command_from_top == CMD_RST)
         count_reg <= '0;
      else if (swap_accept && (count_reg != 16'hFFFF))
         count_reg <= count_reg + 16'd1;
   end

   assign switch_count = count_reg;
`endif

endmodule

// File: tb/tb_kd_leaf_node.sv
// Self-checking bench for kd_leaf_node: directed scenarios then randomized commands
// compared each cycle against a behavioural model of the leaf.
module tb_kd_leaf_node;
   import kd_tree_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  command_from_top;
   logic [23:0] data_from_top;
   logic [4:0]  command_to_top;
   logic [23:0] data_to_top;
`ifdef KD_LEAF_STATS_EN
   logic [15:0] switch_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   bit          m_loaded;
   logic [23:0] m_center;
   logic [23:0] m_data;
   int          m_axis;
   logic [4:0]  m_cmd;
   logic [4:0]  m_prev;
   int          m_count;

   kd_leaf_node dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .command_from_top (command_from_top),
      .data_from_top    (data_from_top),
      .command_to_top   (command_to_top),
      .data_to_top      (data_to_top)
`ifdef KD_LEAF_STATS_EN
      ,
      .switch_count     (switch_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int chan(input logic [23:0] w, input int ax);
      return int'((w >> (16 - 8 * ax)) & 24'hFF);
   endfunction

   task automatic model_reset();
      m_loaded = 1'b0;
      m_center = '0;
      m_data   = '0;
      m_axis   = 0;
      m_cmd    = CMD_NOP;
      m_prev   = CMD_NOP;
      m_count  = 0;
   endtask

   task automatic model_step(input logic [4:0] cmd, input logic [23:0] data);
      if (cmd == CMD_RST) begin
         m_loaded = 1'b0; m_center = '0; m_axis = 0; m_cmd = CMD_RST_DONE; m_count = 0;
      end else if (cmd == CMD_CENTER_FILL) begin
         if (!m_loaded) begin m_center = data; m_loaded = 1'b1; end
         m_cmd = CMD_CENTER_FILL_DONE;
      end else if (cmd inside {CMD_CONFIGURE_SORT_AXIS, CMD_START_SORTING, CMD_SWITCH,
                               CMD_SORT_LEFT_VALIDATE, CMD_SORT_RIGHT_VALIDATE,
                               CMD_EXPOSE_CENTER}) begin
         if (!m_loaded) begin
            m_cmd = CMD_DNE; m_data = '0;
         end else if (cmd == CMD_CONFIGURE_SORT_AXIS) begin
            m_axis = (int'(data[1:0]) == 3) ? 0 : int'(data[1:0]);
            m_cmd  = CMD_CONFIGURE_SORT_AXIS_DONE;
         end else if (cmd == CMD_START_SORTING) begin
            m_cmd = CMD_READY_TO_SORT; m_data = m_center;
         end else if (cmd == CMD_SWITCH) begin
            m_cmd = CMD_SWITCH;
            if (m_prev != CMD_SWITCH) begin
               m_data   = m_center;
               m_center = data;
               if (m_count < 65535) m_count++;
            end
         end else if (cmd == CMD_SORT_LEFT_VALIDATE) begin
            m_cmd = (chan(m_center, m_axis) <= chan(data, m_axis)) ? CMD_VALID_SORT : CMD_BUSY;
         end else if (cmd == CMD_SORT_RIGHT_VALIDATE) begin
            m_cmd = (chan(m_center, m_axis) >= chan(data, m_axis)) ? CMD_VALID_SORT : CMD_BUSY;
         end else begin
            m_cmd = CMD_VALID_DONE; m_data = m_center;
         end
      end else begin
         m_cmd = CMD_NOP;
      end
      m_prev = cmd;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_cmd"}, 32'(command_to_top), 32'(m_cmd));
      chk({tag, "_data"}, 32'(data_to_top), 32'(m_data));
`ifdef KD_LEAF_STATS_EN
      chk({tag, "_count"}, 32'(switch_count), 32'(m_count));
`endif
   endtask

   task automatic step(input logic [4:0] cmd, input logic [23:0] data, input string tag);
      command_from_top = cmd;
      data_from_top    = data;
      @(posedge clk);
      model_step(cmd, data);
      #1;
      $display("[TB] %s cmd=%h data=%h -> resp=%h out=%h", tag, cmd, data,
               command_to_top, data_to_top);
      check_outputs(tag);
   endtask

   logic [4:0] codes [12];

   initial begin
      codes = '{CMD_NOP, CMD_CENTER_FILL, CMD_CONFIGURE_SORT_AXIS, CMD_START_SORTING,
                CMD_SWITCH, CMD_SORT_LEFT_VALIDATE, CMD_SORT_RIGHT_VALIDATE,
                CMD_EXPOSE_CENTER, CMD_RST, 5'h06, 5'h15, CMD_SWITCH};

      reset_n = 1'b0;
      command_from_top = CMD_NOP;
      data_from_top = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset resp=%h out=%h", command_to_top, data_to_top);
      check_outputs("reset");
      reset_n = 1'b1;

      step(CMD_NOP, 24'h0, "t1_nop");
      chk("t1_nop_const", 32'(command_to_top), 32'(CMD_NOP));
      step(CMD_START_SORTING, 24'h0, "t1_empty");
      chk("t1_dne_const", 32'(command_to_top), 32'(CMD_DNE));

      step(CMD_RST, 24'h0, "t2_rst");
      chk("t2_rst_const", 32'(command_to_top), 32'(CMD_RST_DONE));
      step(CMD_CENTER_FILL, 24'h40A0C0, "t2_fill");
      step(CMD_CENTER_FILL, 24'h112233, "t2_refill");
      chk("t2_refill_const", 32'(command_to_top), 32'(CMD_CENTER_FILL_DONE));
      step(CMD_EXPOSE_CENTER, 24'h0, "t2_expose");
      chk("t2_center_const", 32'(data_to_top), 32'h40A0C0);

      step(CMD_CONFIGURE_SORT_AXIS, 24'h1, "t3_axis1");
      step(CMD_SORT_LEFT_VALIDATE, 24'h00B000, "t3_left");
      chk("t3_left_const", 32'(command_to_top), 32'(CMD_VALID_SORT));
      step(CMD_SORT_RIGHT_VALIDATE, 24'h00B000, "t3_right");
      chk("t3_right_const", 32'(command_to_top), 32'(CMD_BUSY));
      step(CMD_CONFIGURE_SORT_AXIS, 24'h3, "t3_axis3");
      step(CMD_SORT_LEFT_VALIDATE, 24'h00B000, "t3_left_ax0");
      chk("t3_left_ax0_const", 32'(command_to_top), 32'(CMD_BUSY));
      step(CMD_SORT_RIGHT_VALIDATE, 24'h00B000, "t3_right_ax0");

      for (int i = 0; i < 4; i++) begin
         step(CMD_SWITCH, 24'h0F0F0F, "t4_switch");
         chk("t4_old_center_const", 32'(data_to_top), 32'h40A0C0);
      end
      step(CMD_EXPOSE_CENTER, 24'h0, "t4_expose");
      chk("t4_new_center_const", 32'(data_to_top), 32'h0F0F0F);
`ifdef KD_LEAF_STATS_EN
      chk("t4_count_const", 32'(switch_count), 32'd1);
`endif

      step(CMD_SWITCH, 24'h123456, "t5_switch");
      step(CMD_SWITCH, 24'h123456, "t5_hold");
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      $display("[TB] t5_async_reset resp=%h out=%h", command_to_top, data_to_top);
      check_outputs("t5_async_reset");
      command_from_top = CMD_NOP;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(CMD_EXPOSE_CENTER, 24'h0, "t5_empty");

      step(CMD_CENTER_FILL, 24'hAABBCC, "t6_fill");
      step(5'h06, 24'h555555, "t6_undef");
      chk("t6_undef_const", 32'(command_to_top), 32'(CMD_NOP));
      step(CMD_EXPOSE_CENTER, 24'h0, "t6_expose");
      chk("t6_center_const", 32'(data_to_top), 32'hAABBCC);

      for (int i = 0; i < 300; i++) begin
         logic [4:0]  rc;
         logic [23:0] rd;
         int          hold;
         rc   = codes[$urandom_range(0, 11)];
         rd   = 24'($urandom);
         hold = $urandom_range(1, 3);
         for (int h = 0; h < hold; h++) step(rc, rd, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
